// File: rtl/result_frame_writer.sv
// Write side of the result frame buffer: accepts a raster pixel stream, generates linear
// buffer addresses and write strobes, checks SOF/EOL framing and reports frame completion.
module result_frame_writer #(
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 320,
  parameter int AW     = 18,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
  input  logic          in_eol,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          frame_done,
  output logic          err_sof,
  output logic          err_eol
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_WRITE    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          err_sof_q, err_sof_d;
  logic          err_eol_q, err_eol_d;

  logic          accept_s, wr_s, resync_s, col_end_s, row_end_s, last_s;
  logic [CW-1:0] cur_col_s;
  logic [RW-1:0] cur_row_s;
  logic [AW-1:0] cur_addr_s;

  assign in_ready   = (state_q == S_WAIT_SOF) || (state_q == S_WRITE);
  assign accept_s   = in_valid & in_ready;
  // An SOF beat always lands on pixel (0,0), whether it opens the frame or resyncs it.
  assign resync_s   = accept_s & in_sof;
  assign wr_s       = accept_s & ((state_q == S_WRITE) | in_sof);
  assign cur_col_s  = resync_s ? {CW{1'b0}} : col_q;
  assign cur_row_s  = resync_s ? {RW{1'b0}} : row_q;
  assign cur_addr_s = resync_s ? {AW{1'b0}} : addr_q;
  assign col_end_s  = (cur_col_s == COL_LAST);
  assign row_end_s  = (cur_row_s == ROW_LAST);
  assign last_s     = wr_s & col_end_s & row_end_s;

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err_sof    = err_sof_q;
  assign err_eol    = err_eol_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_SOF;
        else       state_d = S_IDLE;
      end
      S_WAIT_SOF: begin
        if (last_s)    state_d = S_DONE;
        else if (wr_s) state_d = S_WRITE;
        else           state_d = S_WAIT_SOF;
      end
      S_WRITE: begin
        if (last_s) state_d = S_DONE;
        else        state_d = S_WRITE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, write strobe and status; busy/frame_done are registered views of the state.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_sof_d    = err_sof_q;
    err_eol_d    = err_eol_q;
    frame_done_d = (state_q == S_DONE);
    busy_d       = (state_q != S_IDLE);
    if ((state_q == S_IDLE) && start) begin
      col_d     = {CW{1'b0}};
      row_d     = {RW{1'b0}};
      addr_d    = {AW{1'b0}};
      err_sof_d = 1'b0;
      err_eol_d = 1'b0;
    end else if (wr_s) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = cur_addr_s;
      mem_wdata_d = in_data;
      err_eol_d   = err_eol_q | (in_eol ^ col_end_s);
      err_sof_d   = err_sof_q | (in_sof & (state_q == S_WRITE));
      // Position follows the column count only; a misplaced EOL is flagged, not obeyed.
      if (last_s) begin
        col_d  = {CW{1'b0}};
        row_d  = {RW{1'b0}};
        addr_d = {AW{1'b0}};
      end else if (col_end_s) begin
        col_d  = {CW{1'b0}};
        row_d  = cur_row_s + RW'(1);
        addr_d = cur_addr_s + AW'(1);
      end else begin
        col_d  = cur_col_s + CW'(1);
        row_d  = cur_row_s;
        addr_d = cur_addr_s + AW'(1);
      end
    end else if (accept_s) begin
      err_sof_d = 1'b1;
    end else begin
      mem_we_d = 1'b0;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      addr_q       <= {AW{1'b0}};
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
      err_eol_q    <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_sof_q    <= err_sof_d;
      err_eol_q    <= err_eol_d;
    end
  end

endmodule

// File: tb/tb_result_frame_writer.sv
// Randomised scoreboard bench for result_frame_writer on a reduced 120x12 frame.
module tb_result_frame_writer;
  localparam int W  = 120;
  localparam int H  = 12;
  localparam int AW = 18;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = 8'd0;
  logic          in_sof = 1'b0;
  logic          in_eol = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy, frame_done, err_sof, err_eol;

  result_frame_writer #(.WIDTH(W), .HEIGHT(H), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .in_eol(in_eol), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done),
    .err_sof(err_sof), .err_eol(err_eol)
  );

  always #5 clk = ~clk;

  typedef struct { int e; int a; int d; } wr_t;
  wr_t wq[$];
  int  fdq[$];

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  // Reference model: 0 idle, 1 waiting for SOF, 2 writing, 3 frame complete
  int mode = 0;
  int pos = 0;
  bit m_err_sof = 1'b0;
  bit m_err_eol = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    mode = 0;
    pos = 0;
    m_err_sof = 1'b0;
    m_err_eol = 1'b0;
    wq.delete();
    fdq.delete();
  endtask

  task automatic model_edge(input bit v, input bit s, input bit e, input bit st, input int d);
    bit acc;
    bit wr;
    wr_t w;
    acc = v && (mode == 1 || mode == 2);
    wr = 1'b0;
    if (mode == 3) begin
      mode = 0;
    end else if (mode == 0) begin
      if (st) begin
        mode = 1;
        m_err_sof = 1'b0;
        m_err_eol = 1'b0;
      end
    end else if (acc) begin
      if (s) begin
        if (mode == 2) m_err_sof = 1'b1;
        pos = 0;
        wr = 1'b1;
      end else if (mode == 1) begin
        m_err_sof = 1'b1;
      end else begin
        wr = 1'b1;
      end
    end
    if (wr) begin
      w.e = edge_n; w.a = pos; w.d = d;
      wq.push_back(w);
      if (e != ((pos % W) == W - 1)) m_err_eol = 1'b1;
      pos++;
      mode = 2;
      if (pos == W * H) begin
        mode = 3;
        pos = 0;
        fdq.push_back(edge_n + 1);
      end
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, advance the model.
  task automatic step(input bit r, input bit v, input bit s, input bit e, input bit st, input int d);
    rst_n = r;
    in_valid = v; in_sof = s; in_eol = e; start = st; in_data = d[7:0];
    if (!r) model_reset();
    #1;
    chk("in_ready", in_ready, (mode == 1 || mode == 2));
    @(posedge clk);
    edge_n++;
    if (!rst_n) model_reset();
    else model_edge(v, s, e, st, d);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 255));
  endtask

  task automatic kick();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic send(input int p0, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int p;
      p = p0 + i;
      while ($urandom_range(0, 99) < gap) idle(1);
      step(1'b1, 1'b1, (p == 0), ((p % W) == W - 1), ($urandom_range(0, 49) == 0), $urandom_range(0, 255));
    end
  endtask

  // Monitor: compares DUT outputs to the scoreboard one time unit after each rising edge.
  initial begin
    bit exp_we, exp_fd, prev_fd;
    int last_a, last_d;
    wr_t w;
    prev_fd = 1'b0; last_a = 0; last_d = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_sof", err_sof, 0);
        chk("rst_err_eol", err_eol, 0);
        prev_fd = 1'b0; last_a = 0; last_d = 0;
      end else begin
        exp_we = (wq.size() > 0) && (wq[0].e == edge_n);
        chk("mem_we", mem_we, exp_we);
        if (exp_we) begin
          w = wq.pop_front();
          chk("mem_addr", mem_addr, w.a);
          chk("mem_wdata", mem_wdata, w.d);
          last_a = w.a; last_d = w.d;
        end else begin
          chk("mem_addr_hold", mem_addr, last_a);
          chk("mem_wdata_hold", mem_wdata, last_d);
        end
        exp_fd = (fdq.size() > 0) && (fdq[0] == edge_n);
        if (exp_fd) void'(fdq.pop_front());
        chk("frame_done", frame_done, exp_fd);
        if (exp_fd) chk("busy_at_done", busy, 1);
        if (prev_fd) chk("busy_after_done", busy, 0);
        prev_fd = exp_fd;
        chk("err_sof", err_sof, m_err_sof);
        chk("err_eol", err_eol, m_err_eol);
      end
    end
  end

  initial begin
    #2;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    // clean frame, valid every cycle
    kick(); send(0, W * H, 0); idle(4);
    // clean frame with ~30% idle cycles
    kick(); send(0, W * H, 30); idle(4);
    // three non-SOF beats before the SOF
    kick();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(0, 255));
    send(0, W * H, 10); idle(4);
    // stray EOL at column 100 of row 5
    kick(); send(0, 5 * W + 100, 10);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, $urandom_range(0, 255));
    send(5 * W + 101, W * H - (5 * W + 101), 10); idle(4);
    // SOF re-asserted after 1000 pixels, then a full frame
    kick(); send(0, 1000, 10); send(0, W * H, 10); idle(4);
    // reset in row 10 with traffic still flowing, then a fresh frame
    kick(); send(0, 10 * W + 5, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(0, 255));
    idle(3);
    kick(); send(0, W * H, 20); idle(6);
    chk("pending_writes", wq.size(), 0);
    chk("pending_frame_done", fdq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
